ex_pipe: RTL

- Parametrised successor to the single-cycle execute stage; owns the integer register file and the existing `alu` instance.
- Operand hazards are detected internally by register-index compare, replacing the externally supplied forward flags.
- Adds valid/ready handshakes on input and output, with backpressure, and hardwires x0 to zero.
- Sits between decode and retire in the core pipeline.

---
 rtl/ex_pipe.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/ex_pipe.sv
// ex_pipe: execute stage owning the integer register file and the alu, with valid/ready on both sides.
// Build option EX_FWD_EN: when defined, E-stage results bypass into operand capture; otherwise dependent ops interlock.

module ex_pipe #(
   parameter int XLEN  = 64,
   parameter int NREG  = 32,
   parameter int RBITS = $clog2(NREG)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sub,
   input  logic             ashr,
   input  logic             w,
   input  logic [2:0]       funct3,
   input  logic             imm1,
   input  logic             imm2,
   input  logic [XLEN-1:0]  imm1val,
   input  logic [XLEN-1:0]  imm2val,
   input  logic [RBITS-1:0] rs1,
   input  logic [RBITS-1:0] rs2,
   input  logic [RBITS-1:0] rd,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RBITS-1:0] out_rd,
   output logic [XLEN-1:0]  out_data
);

   logic             e_valid_q, e_valid_d;
   logic [RBITS-1:0] e_rd_q, e_rd_d;
   logic [XLEN-1:0]  op1_q, op1_d;
   logic [XLEN-1:0]  op2_q, op2_d;
   logic             e_sub_q, e_sub_d;
   logic             e_ashr_q, e_ashr_d;
   logic             e_w_q, e_w_d;
   logic [2:0]       e_funct3_q, e_funct3_d;

   logic             out_valid_q, out_valid_d;
   logic [RBITS-1:0] out_rd_q, out_rd_d;
   logic [XLEN-1:0]  out_data_q, out_data_d;

   logic [XLEN-1:0]  rf_q [NREG];
   logic [XLEN-1:0]  rf_rd1, rf_rd2;
   logic [XLEN-1:0]  src1, src2;
   logic [XLEN-1:0]  alu_result;
   logic             adv;
   logic             accept;
   logic             rf_we;

   alu #(
      .XLEN(XLEN)
   ) u_alu (
      .sub    (e_sub_q),
      .ashr   (e_ashr_q),
      .w      (e_w_q),
      .funct3 (e_funct3_q),
      .a      (op1_q),
      .b      (op2_q),
      .y      (alu_result)
   );

   assign adv    = e_valid_q && (!out_valid_q || out_ready);
   assign accept = in_valid && in_ready;
   assign rf_we  = adv && (e_rd_q != '0);

   // x0 is never written, so its read is forced to zero rather than relying on storage.
   assign rf_rd1 = (rs1 == '0) ? '0 : rf_q[rs1];
   assign rf_rd2 = (rs2 == '0) ? '0 : rf_q[rs2];

`ifdef EX_FWD_EN
   logic byp1, byp2;

   assign byp1     = e_valid_q && (e_rd_q == rs1) && (rs1 != '0) && !imm1;
   assign byp2     = e_valid_q && (e_rd_q == rs2) && (rs2 != '0) && !imm2;
   assign src1     = byp1 ? alu_result : rf_rd1;
   assign src2     = byp2 ? alu_result : rf_rd2;
   assign in_ready = !e_valid_q || adv;
`else
   logic hazard;

   // Hold a dependent op until its producer has left E and written the RF.
   assign hazard   = e_valid_q && (e_rd_q != '0) &&
                     ((!imm1 && (rs1 == e_rd_q)) || (!imm2 && (rs2 == e_rd_q)));
   assign src1     = rf_rd1;
   assign src2     = rf_rd2;
   assign in_ready = (!e_valid_q || adv) && !hazard;
`endif

   // NOTE: every always_comb output gets a default before any condition, so no latches are inferred.
   always_comb begin
      e_valid_d  = e_valid_q && !adv;
      e_rd_d     = e_rd_q;
      op1_d      = op1_q;
      op2_d      = op2_q;
      e_sub_d    = e_sub_q;
      e_ashr_d   = e_ashr_q;
      e_w_d      = e_w_q;
      e_funct3_d = e_funct3_q;
      if (accept) begin
         e_valid_d  = 1'b1;
         e_rd_d     = rd;
         op1_d      = imm1 ? imm1val : src1;
         op2_d      = imm2 ? imm2val : src2;
         e_sub_d    = sub;
         e_ashr_d   = ashr;
         e_w_d      = w;
         e_funct3_d = funct3;
      end

      out_valid_d = out_valid_q;
      out_rd_d    = out_rd_q;
      out_data_d  = out_data_q;
      if (adv) begin
         out_valid_d = 1'b1;
         out_rd_d    = e_rd_q;
         out_data_d  = alu_result;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         e_valid_q   <= 1'b0;
         e_rd_q      <= '0;
         op1_q       <= '0;
         op2_q       <= '0;
         e_sub_q     <= 1'b0;
         e_ashr_q    <= 1'b0;
         e_w_q       <= 1'b0;
         e_funct3_q  <= '0;
         out_valid_q <= 1'b0;
         out_rd_q    <= '0;
         out_data_q  <= '0;
      end else begin
         e_valid_q   <= e_valid_d;
         e_rd_q      <= e_rd_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         e_sub_q     <= e_sub_d;
         e_ashr_q    <= e_ashr_d;
         e_w_q       <= e_w_d;
         e_funct3_q  <= e_funct3_d;
         out_valid_q <= out_valid_d;
         out_rd_q    <= out_rd_d;
         out_data_q  <= out_data_d;
      end
   end

   // NOTE: the register file is deliberately not reset; architectural state survives reset and
   // reset only clears e_valid, which already blocks any write of a discarded op.
   always_ff @(posedge clock) begin
      if (rf_we) begin
         rf_q[e_rd_q] <= alu_result;
      end
   end

   assign out_valid = out_valid_q;
   assign out_rd    = out_rd_q;
   assign out_data  = out_data_q;

endmodule

module alu #(
   parameter int XLEN = 64
) (
   input  logic            sub,
   input  logic            ashr,
   input  logic            w,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] y
);

   localparam int SBITS = $clog2(XLEN);

   logic [XLEN-1:0] sum;
   logic [XLEN-1:0] res;
   logic [31:0]     res_w;

   always_comb begin
      sum = sub ? (a - b) : (a + b);

      case (funct3)
         3'd0:    res = sum;
         3'd1:    res = a << b[SBITS-1:0];
         3'd2:    res = XLEN'($signed(a) < $signed(b));
         3'd3:    res = XLEN'(a < b);
         3'd4:    res = a ^ b;
         3'd5:    res = ashr ? XLEN'($signed(a) >>> b[SBITS-1:0]) : (a >> b[SBITS-1:0]);
         3'd6:    res = a | b;
         default: res = a & b;
      endcase

      // Word ops compute on the low 32 bits with 5-bit shift amounts, then sign-extend.
      case (funct3)
         3'd0:    res_w = sum[31:0];
         3'd1:    res_w = a[31:0] << b[4:0];
         3'd5:    res_w = ashr ? 32'($signed(a[31:0]) >>> b[4:0]) : (a[31:0] >> b[4:0]);
         default: res_w = res[31:0];
      endcase

      y = res;
      if (w) begin
         y       = {XLEN{res_w[31]}};
         y[31:0] = res_w;
      end
   end

endmodule
